// File: rtl/trig_job_scheduler.sv
// Round-robin front end sharing one trig engine between two requesters.
// One job in flight; result returned on a valid/ready channel tagged with the requester id.
module trig_job_scheduler #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_angle,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_angle,
  output logic             req1_ready,
  output logic             eng_start,
  output logic [31:0]      eng_angle,
  input  logic             eng_done,
  input  logic [31:0]      eng_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_id,
  output logic             resp_err,
  output logic             busy,
  output logic [CNT_W-1:0] stale_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [31:0]      angle_q, angle_d;
  logic [31:0]      data_q, data_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stale_q, stale_d;

  // State and datapath registers; reset abandons any job in flight without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      angle_q      <= '0;
      data_q       <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      stale_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      angle_q      <= angle_d;
      data_q       <= data_d;
      id_q         <= id_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      stale_q      <= stale_d;
    end
  end

  // Arbitration, job sequencing and stale-completion accounting.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    angle_d      = angle_q;
    data_d       = data_q;
    id_d         = id_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    stale_d      = stale_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    eng_start    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Requester 0 wins unless requester 1 is also waiting and 0 was served last.
        if (req0_valid && (!req1_valid || last_grant_q)) begin
          req0_ready   = 1'b1;
          angle_d      = req0_angle;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = StIssue;
        end else if (req1_valid) begin
          req1_ready   = 1'b1;
          angle_d      = req1_angle;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        // Completion takes priority over a timeout in the same cycle.
        if (eng_done) begin
          data_d  = eng_result;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Completions outside WAIT belong to no live job; count them, saturating.
    if (eng_done && (state_q != StWait) && (stale_q != '1)) begin
      stale_d = stale_q + CntOne;
    end
  end

  assign eng_angle  = angle_q;
  assign resp_valid = (state_q == StResp);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != StIdle);
  assign stale_cnt  = stale_q;

endmodule
